// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg                                                           |
// | Shared op codes, FSM encoding and constants for the HI/LO unit.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  localparam int unsigned c_ITER_DEF = 32;

  localparam logic [2:0] c_OP_NOP   = 3'd0;
  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_CALC = 2'd1;
  localparam logic [1:0] c_ST_FIX  = 2'd2;

  localparam logic [31:0] c_DIV0_LO = 32'hFFFF_FFFF;

  // Magnitude of a value; 0x80000000 maps onto itself, which is what the unsigned datapath wants.
  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | exe_muldiv_unit                                                      |
// | Iterative MIPS-style multiply/divide unit owning the HI/LO registers.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module exe_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = c_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall_req
);

  localparam int unsigned c_CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(ITER - 1);

  logic [1:0]      r_state;
  logic [c_CW-1:0] r_count;
  logic [63:0]     r_acc;
  logic [31:0]     r_opd;
  logic            r_is_div;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_div0;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic            r_done;

  logic        w_op_md;
  logic        w_signed;
  logic        w_op_div;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_msum;
  logic [63:0] w_mul_next;
  logic        w_dfit;
  logic [31:0] w_ddiff;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_op_md  = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                    (op == c_OP_DIV)  || (op == c_OP_DIVU);
  assign w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
  assign w_op_div = (op == c_OP_DIV)  || (op == c_OP_DIVU);
  assign w_mag_a  = f_mag(a, w_signed);
  assign w_mag_b  = f_mag(b, w_signed);

  // Shift-add: multiplier sits in acc[31:0] and is consumed LSB first.
  assign w_msum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
  assign w_mul_next = {w_msum, r_acc[31:1]};

  // Restoring divide: the partial remainder after the shift needs 33 bits for the compare.
  assign w_dfit     = r_acc[63:31] >= {1'b0, r_opd};
  assign w_ddiff    = r_acc[62:31] - r_opd;
  assign w_div_next = w_dfit ? {w_ddiff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem  = r_neg_rem ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start && !flush) begin
            if (w_op_md) begin
              r_state   <= c_ST_CALC;
              r_count   <= c_CNT_INIT;
              r_is_div  <= w_op_div;
              r_opd     <= w_op_div ? w_mag_b : w_mag_a;
              r_acc     <= {32'd0, (w_op_div ? w_mag_a : w_mag_b)};
              r_neg_res <= w_signed && (a[31] ^ b[31]);
              r_neg_rem <= w_signed && a[31];
              r_div0    <= w_op_div && (b == 32'd0);
            end else if (op == c_OP_MTHI) begin
              r_hi <= a;
            end else if (op == c_OP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        c_ST_CALC: begin
          if (flush) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_acc   <= r_is_div ? w_div_next : w_mul_next;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
              r_state <= c_ST_FIX;
            end
          end
        end
        c_ST_FIX: begin
          r_state <= c_ST_IDLE;
          if (!flush) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              // Divide by zero leaves |a| as remainder, so the sign fix-up restores a itself.
              r_hi <= w_rem;
              r_lo <= r_div0 ? c_DIV0_LO : w_quo;
            end else begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign done      = r_done;
  assign busy      = (r_state == c_ST_CALC) || (r_state == c_ST_FIX);
  assign stall_req = busy && (start || rd_hilo);

endmodule
`default_nettype wire
